// File: rtl/tdm_demux.sv
// Receive end of a rotating-select TDM link.
// Samples arrive one per valid cycle on a shared line. A frame-sync marker
// tags lane 0. Each sample is steered into its lane register. Once a frame is
// complete, a coherent snapshot of all lanes is published together with a
// one-cycle frame_done pulse. A misplaced or missing sync raises sync_err:
// a misplaced sync realigns the frame, a missing sync drops back to hunting.
module tdm_demux #(
  parameter int LANES = 4,
  parameter int WIDTH = 1,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  output logic [LANES*WIDTH-1:0] y,
  output logic [LANES-1:0]       lane_valid,
  output logic [LANES*WIDTH-1:0] y_frame,
  output logic                   frame_done,
  output logic [SEL_W-1:0]       sel,
  output logic                   locked,
  output logic                   sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slot index of the final lane in a frame. The counter wraps here, so
  // codes above LANES-1 are never reached, even if SEL_W leaves spare codes.
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LANES - 1);
  localparam logic [LANES-1:0] LANE0_BIT = LANES'(1);

  state_t                 state_q;
  logic [LANES*WIDTH-1:0] y_q;
  logic [LANES*WIDTH-1:0] y_frame_q;
  logic [LANES-1:0]       lane_valid_q;
  logic [SEL_W-1:0]       sel_q;
  logic                   frame_done_q;
  logic                   sync_err_q;

  // Candidate next values of the lane bank.
  // y_start_d: din written into lane 0 (frame start or realign).
  // y_slot_d:  din written into the lane selected by sel_q.
  // slot_bit_d is the one-hot flag of the lane that sel_q selects.
  logic [LANES*WIDTH-1:0] y_start_d;
  logic [LANES*WIDTH-1:0] y_slot_d;
  logic [LANES-1:0]       slot_bit_d;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [SEL_W-1:0] SLOT = SEL_W'(gi);

      if (gi == 0) begin : g_first
        assign y_start_d[gi*WIDTH +: WIDTH] = din;
      end else begin : g_rest
        assign y_start_d[gi*WIDTH +: WIDTH] = y_q[gi*WIDTH +: WIDTH];
      end

      assign y_slot_d[gi*WIDTH +: WIDTH] = (sel_q == SLOT) ? din : y_q[gi*WIDTH +: WIDTH];
      assign slot_bit_d[gi]              = (sel_q == SLOT);
    end
  endgenerate

  // Frame-alignment FSM and all registered outputs. The pulse outputs default
  // low every cycle. A cycle with din_valid low leaves every other register
  // unchanged and ignores frame_sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      y_q          <= '0;
      y_frame_q    <= '0;
      lane_valid_q <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            // Discard everything until a sync-tagged sample shows up.
            if (frame_sync) begin
              y_q          <= y_start_d;
              lane_valid_q <= LANE0_BIT;
              sel_q        <= SEL_W'(1);
              state_q      <= RUN;
            end
          end
          RUN: begin
            if (frame_sync) begin
              // A sync arriving mid-frame drops the partial frame and
              // restarts at lane 0. y_frame is left untouched in that case.
              if (sel_q != '0) begin
                sync_err_q <= 1'b1;
              end
              y_q          <= y_start_d;
              lane_valid_q <= LANE0_BIT;
              sel_q        <= SEL_W'(1);
            end else if (sel_q == '0) begin
              // A lane-0 slot without its marker means alignment is lost.
              sync_err_q   <= 1'b1;
              lane_valid_q <= '0;
              sel_q        <= '0;
              state_q      <= HUNT;
            end else begin
              y_q <= y_slot_d;
              if (sel_q == LAST_SEL) begin
                // The final sample is merged into the snapshot on this same edge.
                y_frame_q    <= y_slot_d;
                frame_done_q <= 1'b1;
                lane_valid_q <= '0;
                sel_q        <= '0;
              end else begin
                lane_valid_q <= lane_valid_q | slot_bit_d;
                sel_q        <= sel_q + SEL_W'(1);
              end
            end
          end
          default: begin
            state_q <= HUNT;
          end
        endcase
      end
    end
  end

  assign y          = y_q;
  assign y_frame    = y_frame_q;
  assign lane_valid = lane_valid_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux.
// The driver feeds directed scenarios and then random traffic. For every
// cycle it drives, it pushes the expected post-edge outputs, computed by a
// slot/array reference model, into a queue. A separate monitor pops one
// entry after each clock edge and compares it with the DUT outputs.
module tb_tdm_demux;

  localparam int LANES = 4;
  localparam int WIDTH = 1;
  localparam int SEL_W = 2;

  typedef struct packed {
    logic [LANES*WIDTH-1:0] y;
    logic [LANES-1:0]       lv;
    logic [LANES*WIDTH-1:0] yf;
    logic                   fd;
    logic [SEL_W-1:0]       sel;
    logic                   lk;
    logic                   se;
  } snap_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic                   frame_sync;
  logic [LANES*WIDTH-1:0] y;
  logic [LANES-1:0]       lane_valid;
  logic [LANES*WIDTH-1:0] y_frame;
  logic                   frame_done;
  logic [SEL_W-1:0]       sel;
  logic                   locked;
  logic                   sync_err;

  int tests = 0;
  int fails = 0;
  int fd_count = 0;
  snap_t exp_q[$];

  tdm_demux #(.LANES(LANES), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .y(y), .lane_valid(lane_valid),
    .y_frame(y_frame), .frame_done(frame_done), .sel(sel),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The model tracks the frame as a list of lanes plus the position of the
  // next sample within the frame.
  bit               m_locked;
  int               m_pos;
  logic [WIDTH-1:0] m_lanes[LANES];
  bit               m_written[LANES];
  logic [WIDTH-1:0] m_frame[LANES];
  bit               m_fd;
  bit               m_se;

  function automatic void m_clear_written();
    for (int k = 0; k < LANES; k++) m_written[k] = 1'b0;
  endfunction

  function automatic void model_reset();
    m_locked = 1'b0; m_pos = 0; m_fd = 1'b0; m_se = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      m_lanes[k] = '0; m_frame[k] = '0; m_written[k] = 1'b0;
    end
  endfunction

  function automatic void start_frame(input logic [WIDTH-1:0] d);
    m_clear_written();
    m_lanes[0] = d; m_written[0] = 1'b1; m_pos = 1; m_locked = 1'b1;
  endfunction

  function automatic void model_step(input bit v, input bit fs, input logic [WIDTH-1:0] d);
    m_fd = 1'b0; m_se = 1'b0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) start_frame(d);
    end else if (fs) begin
      if (m_pos != 0) m_se = 1'b1;
      start_frame(d);
    end else if (m_pos == 0) begin
      m_se = 1'b1; m_locked = 1'b0; m_clear_written();
    end else begin
      m_lanes[m_pos] = d; m_written[m_pos] = 1'b1; m_pos++;
      if (m_pos == LANES) begin
        for (int k = 0; k < LANES; k++) m_frame[k] = m_lanes[k];
        m_fd = 1'b1; m_pos = 0; m_clear_written();
      end
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      s.y[k*WIDTH +: WIDTH]  = m_lanes[k];
      s.yf[k*WIDTH +: WIDTH] = m_frame[k];
      s.lv[k]                = m_written[k];
    end
    s.fd = m_fd; s.se = m_se; s.lk = m_locked; s.sel = SEL_W'(m_pos);
    return s;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One driven cycle: apply inputs at the falling edge, predict the outcome.
  task automatic step(input bit v, input bit fs, input logic [WIDTH-1:0] d);
    @(negedge clk);
    din_valid = v; frame_sync = fs; din = d;
    model_step(v, fs, d);
    exp_q.push_back(model_snap());
  endtask

  // Wait for the edge that consumes the last step, then settle.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  initial begin
    snap_t e, a;
    forever begin
      @(posedge clk);
      #2;
      if (frame_done) fd_count++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{y: y, lv: lane_valid, yf: y_frame, fd: frame_done, sel: sel, lk: locked, se: sync_err};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL scoreboard @%0t: got y=%h lv=%h yf=%h fd=%b sel=%0d lk=%b se=%b expected y=%h lv=%h yf=%h fd=%b sel=%0d lk=%b se=%b",
                   $time, a.y, a.lv, a.yf, a.fd, a.sel, a.lk, a.se,
                   e.y, e.lv, e.yf, e.fd, e.sel, e.lk, e.se);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int fd_before;
    int r;
    bit v, fs;
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_y", y, 0);
    check("reset_yframe", y_frame, 0);
    check("reset_lv", lane_valid, 0);
    check("reset_sel", sel, 0);
    check("reset_flags", {locked, frame_done, sync_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Hunt discard followed by the basic frame.
    fd_before = fd_count;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, WIDTH'(i % 2));
      after_edge();
      check("hunt_locked", locked, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    after_edge();
    check("basic_yframe", y_frame, 4'b1010);
    check("basic_fd", frame_done, 1);
    check("basic_sel", sel, 0);
    check("basic_locked", locked, 1);
    step(1'b0, 1'b0, 1'b0);
    after_edge();
    check("basic_fd_pulse", frame_done, 0);
    check("hunt_one_fd", fd_count - fd_before, 1);

    // Stall with a stray frame_sync while din_valid is low.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    after_edge();
    check("stall_no_err", sync_err, 0);
    check("stall_sel", sel, 2);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    after_edge();
    check("stall_yframe", y_frame, 4'b1010);
    check("stall_fd", frame_done, 1);

    // Early sync on the third sample.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    after_edge();
    check("early_err", sync_err, 1);
    check("early_yframe", y_frame, 4'b1010);
    check("early_lv", lane_valid, 4'b0001);
    check("early_sel", sel, 1);
    check("early_no_fd", frame_done, 0);

    // Complete the realigned frame, then a full frame, then one without sync.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    after_edge();
    check("miss_first_fd", frame_done, 1);
    check("miss_first_yframe", y_frame, 4'b0011);
    step(1'b1, 1'b0, 1'b1);
    after_edge();
    check("miss_err", sync_err, 1);
    check("miss_locked", locked, 0);
    check("miss_lv", lane_valid, 0);
    check("miss_yframe", y_frame, 4'b0011);
    check("miss_no_fd", frame_done, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges after two samples.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    check("pre_rst_sel", sel, 2);
    rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0;
    #1;
    check("arst_y", y, 0);
    check("arst_lv", lane_valid, 0);
    check("arst_sel", sel, 0);
    check("arst_locked", locked, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      after_edge();
      check("post_rst_discard", {locked, y}, 0);
    end

    // Randomized traffic: syncs mostly where expected, occasionally misplaced.
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 15));
      v  = ($urandom_range(0, 3) != 0);
      fs = (m_pos == 0) ? (r < 13) : (r == 0);
      step(v, fs, WIDTH'($urandom));
    end
    step(1'b0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of a rotating-select TDM mux link.
- Accepts one sample per valid cycle on a shared line, tagged by a frame-sync marker on lane 0.
- Steers each sample to its lane register and publishes a coherent snapshot of all lanes once per complete frame.
- Sits downstream of the select-counter-driven mux and feeds per-lane consumers.

Parameters:
- LANES, 4, number of time slots per frame (≥2).
- WIDTH, 1, bits per sample.
- SEL_W, 2, width of the slot counter; must satisfy 2^SEL_W ≥ LANES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  serial sample from the mux.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  current sample belongs to lane 0; qualified by din_valid.
- y  output  LANES*WIDTH  live lane registers; lane k occupies bits [k*WIDTH +: WIDTH].
- lane_valid  output  LANES  lane k written in the current frame.
- y_frame  output  LANES*WIDTH  snapshot of the last complete frame.
- frame_done  output  1  one-cycle pulse when y_frame updates.
- sel  output  SEL_W  slot the next accepted sample will be written to.
- locked  output  1  FSM is in RUN.
- sync_err  output  1  one-cycle pulse on a misaligned frame_sync.

Behaviour:
- Reset (async, immediate): y, y_frame, lane_valid, sel = 0; frame_done, sync_err, locked = 0; FSM = HUNT.
- All outputs are registered. A sample accepted at edge N is visible after edge N; latency is 1 cycle.
- A cycle with din_valid=0 changes nothing: registers hold, and frame_sync is ignored.
- HUNT state:
  - din_valid=1, frame_sync=0: sample discarded, no state change.
  - din_valid=1, frame_sync=1: write lane 0, set lane_valid to 1 (lane 0 only), sel←1, go to RUN.
- RUN state, din_valid=1, frame_sync=0:
  - Write lane sel, set lane_valid[sel].
  - If sel=LANES-1: sel←0, y_frame←y with the final sample merged in the same edge, frame_done=1, lane_valid←0.
  - Otherwise sel←sel+1.
- RUN state, din_valid=1, frame_sync=1, sel=0: normal frame start. Write lane 0, lane_valid←1 (lane 0 only), sel←1.
- RUN state, din_valid=1, frame_sync=1, sel≠0: misalignment.
  - sync_err=1.
  - Partial frame dropped: y_frame untouched, no frame_done.
  - Realign: write lane 0, lane_valid←1 (lane 0 only), sel←1. Stay in RUN.
- Missing sync: in RUN, sel=0 with din_valid=1 and frame_sync=0 counts as a lost sync.
  - sync_err=1, sample discarded, FSM→HUNT, lane_valid←0, sel←0.
  - y and y_frame retain their last values.
- Wrap-around: sel counts 0..LANES-1 only. Values ≥LANES are never reached, including when LANES < 2^SEL_W.
- Simultaneous events: the last-lane write and the y_frame capture use the same edge; y_frame includes the final sample.
- Reset mid-frame: partial frame lost, FSM→HUNT; the next frame_sync is required before any write.
- frame_done and sync_err are never asserted together.

Test Plan:
- Basic frame (LANES=4, WIDTH=1):
  - Stimulus: din 0,1,0,1 on 4 consecutive valid cycles, frame_sync on the first.
  - Response: y_frame=4'b1010 (lane 0 at LSB) and frame_done high for exactly 1 cycle after the 4th edge; sel returns to 0; locked=1.
- Hunt discard:
  - Stimulus: after reset, 3 valid samples with frame_sync=0, then the basic frame.
  - Response: locked stays 0 for the first 3; y_frame=4'b1010; exactly one frame_done.
- Stall tolerance:
  - Stimulus: the basic frame with din_valid=0 for 2 cycles between samples 2 and 3, and frame_sync=1 asserted during a stall cycle.
  - Response: stall ignored, no sync_err; y_frame=4'b1010, 2 cycles later than the basic case.
- Early sync:
  - Stimulus: frame_sync on the 3rd sample of a frame (sel=2).
  - Response: sync_err pulses; y_frame unchanged; lane_valid=4'b0001; sel=1.
- Missing sync:
  - Stimulus: two back-to-back frames, the second without frame_sync.
  - Response: first frame yields frame_done; at the second frame's first sample, sync_err pulses, locked→0, lane_valid=0, and y_frame holds the first frame.
- Async reset:
  - Stimulus: rst asserted between clock edges after 2 samples of a frame.
  - Response: all outputs 0 immediately, before the next edge; after release, samples without frame_sync are discarded.
